// File: rtl/pe_mac_array_cell.sv
// Systolic MAC cell with weight-stationary and output-stationary run modes plus registered east/south forwarding.
// Define PE_SAT_EN to clamp every sum to the ACC_W signed range and report clamps on ovf; otherwise sums wrap.
module pe_mac_array_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  input  logic              w_load,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_vld_out,
  output logic              busy,
  output logic              err,
  output logic              ovf
);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN_WS, RUN_OS, DRAIN} state_e;

  // Returns {clamped, sum}; the clamp bit is always 0 in the wrapping build.
  function automatic logic [ACC_W:0] add_fit(input logic [ACC_W-1:0] x, input logic [PROD_W-1:0] p);
`ifdef PE_SAT_EN
    logic [ACC_W:0] s;
    s = (ACC_W+1)'($signed(x)) + (ACC_W+1)'($signed(p));
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return {1'b0, s[ACC_W-1:0]};
`else
    logic [ACC_W-1:0] s;
    s = x + ACC_W'($signed(p));
    return {1'b0, s};
`endif
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   w_q, w_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    psum_q, psum_d;
  logic                psum_vld_q, psum_vld_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                a_vld_q, b_vld_q;

  logic [PROD_W-1:0]   a_ext, w_ext, b_ext, ws_prod, os_prod;
  logic [ACC_W:0]      ws_fit, os_fit;

  // Operands are widened before multiplying so the product keeps all 2*DATA_W bits.
  assign a_ext   = PROD_W'($signed(a_in));
  assign w_ext   = PROD_W'($signed(w_q));
  assign b_ext   = PROD_W'($signed(b_in));
  assign ws_prod = a_ext * w_ext;
  assign os_prod = a_ext * b_ext;
  assign ws_fit  = add_fit(psum_in, ws_prod);
  assign os_fit  = add_fit(acc_q, os_prod);

  always_comb begin
    state_d    = state_q;
    w_d        = (w_load && b_vld_in) ? b_in : w_q;
    acc_d      = acc_q;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    err_d      = err_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = mode ? RUN_OS : RUN_WS;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          acc_d   = '0;
        end
      end
      RUN_WS: begin
        if (a_vld_in) begin
          psum_d     = ws_fit[ACC_W-1:0];
          psum_vld_d = 1'b1;
          if (ws_fit[ACC_W]) ovf_d = 1'b1;
        end
        if (stop) state_d = IDLE;
      end
      RUN_OS: begin
        if (a_vld_in && b_vld_in) begin
          acc_d = os_fit[ACC_W-1:0];
          if (os_fit[ACC_W]) ovf_d = 1'b1;
        end else if (a_vld_in != b_vld_in) begin
          err_d = 1'b1;
        end
        // The stop-cycle pair is folded in before the result is presented in DRAIN.
        if (stop) begin
          psum_d     = acc_d;
          psum_vld_d = 1'b1;
          acc_d      = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      w_q        <= '0;
      acc_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      b_q        <= '0;
      b_vld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      acc_q      <= acc_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      a_q        <= a_in;
      a_vld_q    <= a_vld_in;
      b_q        <= b_in;
      b_vld_q    <= b_vld_in;
    end
  end

  assign a_out        = a_q;
  assign a_vld_out    = a_vld_q;
  assign b_out        = b_q;
  assign b_vld_out    = b_vld_q;
  assign psum_out     = psum_q;
  assign psum_vld_out = psum_vld_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign ovf          = ovf_q;
endmodule

// File: doc/pe_mac_array_cell.md
# pe_mac_array_cell

Parametrised systolic processing element: the next-generation MAC cell for the team's systolic array, replacing the fixed 8-bit parallel/serial PE. It supports two runtime modes: weight-stationary (WS), which computes a partial sum per cycle, and output-stationary (OS), which accumulates locally and drains. Operands are signed two's complement with valid qualifiers and a registered east/south forwarding path. Cells tile directly into an N×M grid: a_out feeds the east neighbour's a_in, b_out feeds the south neighbour's b_in, and psum_out feeds the south neighbour's psum_in.

## Interface
- DATA_W, 8, operand width (signed)
- ACC_W, 20, partial-sum and accumulator width (signed); must satisfy ACC_W ≥ 2·DATA_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = WS, 1 = OS; sampled only on start in IDLE
- start  in  1  leave IDLE and enter the run state for the sampled mode
- stop  in  1  end the run
- w_load  in  1  with b_vld_in, load b_in into the weight register
- a_in / a_vld_in  in  DATA_W / 1  west operand and its valid
- b_in / b_vld_in  in  DATA_W / 1  north operand or weight, and its valid
- psum_in  in  ACC_W  partial sum from the north (WS only)
- a_out / a_vld_out  out  DATA_W / 1  registered copy of a_in / a_vld_in
- b_out / b_vld_out  out  DATA_W / 1  registered copy of b_in / b_vld_in
- psum_out / psum_vld_out  out  ACC_W / 1  result and its 1-cycle valid
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky valid-mismatch flag (OS); cleared on start
- ovf  out  1  sticky overflow flag; cleared on start

## Operation
- States: IDLE, RUN_WS, RUN_OS, DRAIN.
  - IDLE + start: go to RUN_WS when mode=0, RUN_OS when mode=1.
  - RUN_WS + stop: go to IDLE.
  - RUN_OS + stop: go to DRAIN.
  - DRAIN: go to IDLE unconditionally after 1 cycle.
- stop is ignored in IDLE. start is ignored outside IDLE. start and stop together in IDLE: start wins, stop is ignored.
- Weight register: loaded when w_load && b_vld_in, in any state.
- Forwarding: a_out, a_vld_out, b_out and b_vld_out register their inputs every cycle, in every state.
- RUN_WS, cycle with a_vld_in=1:
  - psum_out ← psum_in + sext(a_in × w); psum_vld_out ← 1.
  - Otherwise psum_vld_out ← 0 and psum_out holds.
- RUN_OS, cycle with a_vld_in && b_vld_in: acc ← acc + sext(a_in × b_in).
- RUN_OS, cycle where exactly one of a_vld_in / b_vld_in is high: no accumulate; err ← 1.
- DRAIN: psum_out ← acc, including any pair accepted on the stop cycle; psum_vld_out ← 1; acc ← 0.
- start clears err, ovf and acc.
- Arithmetic:
  - Product is a full 2·DATA_W signed result, sign-extended to ACC_W.
  - Overflow handling follows Configuration.

## Timing
- Reset values, applied asynchronously while rst=0: state IDLE, weight 0, acc 0; every output 0, including busy, err and ovf.
- Reset in the middle of a run aborts it with no drain output.
- WS latency: 1 cycle from a_vld_in to psum_vld_out.
- OS: the last accepted pair is visible in psum_out on the DRAIN cycle, one edge after stop.
- Forwarding latency: 1 cycle.
- w_load in the same cycle as a WS MAC: the MAC uses the old weight; the new weight applies from the next cycle.
- stop together with a valid operand: that operand is processed, in both modes.
- busy rises on the edge after start. It falls on the edge leaving RUN_WS or DRAIN.

## Configuration
- PE_SAT_EN defined:
  - Every sum clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - ovf sets on any clamp.
- PE_SAT_EN undefined:
  - Sums wrap modulo 2^ACC_W.
  - ovf is tied to 0.

## Test plan
- WS: load w=3; start with mode=0; a_in=5, psum_in=10 → next cycle psum_out=25, psum_vld_out=1; a_out=5.
- WS weight update: w_load with b_in=−2 in the same cycle as a_in=4, psum_in=0 (old w=3) → 12; then a_in=4 → −8.
- OS: pairs (2,3), (−4,5), (7,7), then stop with pair (1,1) → DRAIN psum_out=36, psum_vld_out=1; afterwards acc=0 and state IDLE.
- Saturation, ACC_W=16: accumulate (127,127) three times → PE_SAT_EN defined: 32767 with ovf=1; undefined: −17149 with ovf=0.
- Valid mismatch: in RUN_OS, a_vld_in=1 with b_vld_in=0 → acc unchanged, err=1; the next start clears it.
- rst low during RUN_OS with acc=50 → all outputs 0, busy=0, no psum_vld_out pulse. start and stop together in IDLE → enters the run state.
